// File: rtl/gs_update_unit.sv
// rtl/gs_update_unit.sv - Gauss-Seidel update datapath, sweep control and result drain
//
// Optional build macro: GS_ROUND_EN (round-to-nearest, ties away from zero;
// default build truncates toward zero).
//
// Ports:
//   clk_in, rst_in          clock, synchronous active-high reset
//   start_in                pulse; that same cycle is element 0 of sweep 0
//   b_in                    signed integer b of the current element
//   x1_in..x6_in            neighbours x[i-1], x[i+1], x[i-2], x[i+2], x[i-3], x[i+3] (s16.16)
//   x_out, x_valid_out      registered updated x[i] and its strobe
//   result_out              final-sweep x[k], k = 0..N_ELEM-1 in order
//   result_valid_out        result_out valid (DRAIN)
//   result_ready_in         downstream accepts result_out
//   busy_out                high while SOLVE or DRAIN

module gs_update_unit #(
    parameter int N_ELEM = 16,
    parameter int N_ITER = 64
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        start_in,
    input  logic [15:0] b_in,
    input  logic [31:0] x1_in,
    input  logic [31:0] x2_in,
    input  logic [31:0] x3_in,
    input  logic [31:0] x4_in,
    input  logic [31:0] x5_in,
    input  logic [31:0] x6_in,
    output logic [31:0] x_out,
    output logic        x_valid_out,
    output logic        result_valid_out,
    input  logic        result_ready_in,
    output logic [31:0] result_out,
    output logic        busy_out
);

    localparam int EW = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
    localparam logic [EW-1:0] LAST_ELEM = EW'(N_ELEM - 1);
    localparam logic [7:0]    LAST_ITER = 8'(N_ITER - 1);

    // floor(2^48 / 20). With |sum| < 2^39 the scaled product under-estimates
    // the quotient by at most one, so a single remainder correction is exact.
    localparam logic [43:0] RECIP_20 = 44'd14073748835532;

    localparam logic signed [39:0] Q_MAX = 40'sh00_7FFF_FFFF;
    localparam logic signed [39:0] Q_MIN = 40'shFF_8000_0000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SOLVE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [EW-1:0]   elem_cnt;
    logic [7:0]      iter_cnt;
    logic [EW-1:0]   rd_ptr;
    logic [31:0]     result_buf [N_ELEM];

    logic            solve_cycle;
    logic            last_sweep;
    logic            end_of_run;

    logic signed [39:0] b_ext;
    logic signed [39:0] s12;
    logic signed [39:0] s34;
    logic signed [39:0] s56;
    logic signed [39:0] sum;
    logic               sum_neg;
    logic [39:0]        mag;
    logic [39:0]        mag_adj;
    logic [35:0]        q0;
    logic [39:0]        rem;
    logic [35:0]        q_mag;
    logic signed [39:0] q;
    logic [31:0]        q_sat;

    // ------------------------------------------------------------------
    // Arithmetic: sum / 20 on the magnitude, sign restored afterwards so
    // truncation (and rounding) is symmetric about zero.
    // ------------------------------------------------------------------
    always_comb begin
        b_ext   = {{8{b_in[15]}}, b_in, 16'h0000};
        s12     = 40'($signed(x1_in)) + 40'($signed(x2_in));
        s34     = 40'($signed(x3_in)) + 40'($signed(x4_in));
        s56     = 40'($signed(x5_in)) + 40'($signed(x6_in));
        sum     = b_ext + s12 * 40'sd13 - s34 * 40'sd6 + s56;
        sum_neg = sum[39];
        mag     = sum_neg ? 40'(-sum) : 40'(sum);
`ifdef GS_ROUND_EN
        // Adding half the divisor to the magnitude gives ties away from zero.
        mag_adj = mag + 40'd10;
`else
        mag_adj = mag;
`endif
        q0      = 36'((84'(mag_adj) * 84'(RECIP_20)) >> 48);
        rem     = mag_adj - 40'(q0) * 40'd20;
        q_mag   = (rem >= 40'd20) ? q0 + 36'd1 : q0;
        q       = sum_neg ? -$signed({4'b0000, q_mag}) : $signed({4'b0000, q_mag});
        if (q > Q_MAX) begin
            q_sat = 32'h7FFF_FFFF;
        end else if (q < Q_MIN) begin
            q_sat = 32'h8000_0000;
        end else begin
            q_sat = q[31:0];
        end
    end

    // ------------------------------------------------------------------
    // FSM next state. The start cycle already processes element 0, so it
    // counts as a solve cycle even though the state is still IDLE.
    // ------------------------------------------------------------------
    assign last_sweep = (iter_cnt == LAST_ITER);
    assign end_of_run = (elem_cnt == LAST_ELEM) && last_sweep;

    always_comb begin
        state_nxt   = state;
        solve_cycle = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_in) begin
                    solve_cycle = 1'b1;
                    state_nxt   = end_of_run ? S_DRAIN : S_SOLVE;
                end
            end
            S_SOLVE: begin
                solve_cycle = 1'b1;
                if (end_of_run) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (result_ready_in && (rd_ptr == LAST_ELEM)) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state       <= S_IDLE;
            elem_cnt    <= '0;
            iter_cnt    <= '0;
            rd_ptr      <= '0;
            x_out       <= '0;
            x_valid_out <= 1'b0;
            busy_out    <= 1'b0;
        end else begin
            state       <= state_nxt;
            busy_out    <= (state_nxt != S_IDLE);
            x_valid_out <= solve_cycle;
            if (solve_cycle) begin
                x_out <= q_sat;
                if (elem_cnt == LAST_ELEM) begin
                    elem_cnt <= '0;
                    iter_cnt <= last_sweep ? 8'd0 : iter_cnt + 8'd1;
                end else begin
                    elem_cnt <= elem_cnt + 1'b1;
                end
            end
            // N_ELEM is a power of two, so the final transfer wraps rd_ptr
            // back to 0, ready for the next drain.
            if ((state == S_DRAIN) && result_ready_in) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Only the last sweep writes the buffer; it needs no reset.
    always_ff @(posedge clk_in) begin
        if (solve_cycle && last_sweep) begin
            result_buf[elem_cnt] <= q_sat;
        end
    end

    assign result_valid_out = (state == S_DRAIN);
    assign result_out       = result_valid_out ? result_buf[rd_ptr] : 32'h0000_0000;

endmodule

// File: tb/tb_gs_update_unit.sv
// tb/tb_gs_update_unit.sv - self-checking bench for gs_update_unit (N_ITER=2)

module tb_gs_update_unit;

    localparam int NE = 16;
    localparam int NI = 2;
    localparam int NRUN = NE * NI;

    localparam int MODE_RAND   = 0;
    localparam int MODE_DIRECT = 1;
    localparam int MODE_RAMP   = 2;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        start_in;
    logic [15:0] b_in;
    logic [31:0] x1_in, x2_in, x3_in, x4_in, x5_in, x6_in;
    logic [31:0] x_out;
    logic        x_valid_out;
    logic        result_valid_out;
    logic        result_ready_in;
    logic [31:0] result_out;
    logic        busy_out;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] exp_buf [NE];

    // Directed vectors: b, x1, x2 (x3..x6 = 0) and expected quotient.
    logic [15:0] d_b  [7] = '{16'h0014, 16'hFFEC, 16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};
    logic [31:0] d_x1 [7] = '{32'h0, 32'h0, 32'h0001_0000, 32'h0, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0};
`ifdef GS_ROUND_EN
    logic [31:0] d_e  [7] = '{32'h0001_0000, 32'hFFFF_0000, 32'h0001_4CCD, 32'h0000_0CCD,
                              32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_F333};
`else
    logic [31:0] d_e  [7] = '{32'h0001_0000, 32'hFFFF_0000, 32'h0001_4CCC, 32'h0000_0CCC,
                              32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_F334};
`endif

    gs_update_unit #(.N_ELEM(NE), .N_ITER(NI)) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .start_in         (start_in),
        .b_in             (b_in),
        .x1_in            (x1_in),
        .x2_in            (x2_in),
        .x3_in            (x3_in),
        .x4_in            (x4_in),
        .x5_in            (x5_in),
        .x6_in            (x6_in),
        .x_out            (x_out),
        .x_valid_out      (x_valid_out),
        .result_valid_out (result_valid_out),
        .result_ready_in  (result_ready_in),
        .result_out       (result_out),
        .busy_out         (busy_out)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [31:0] ref_q(input logic signed [15:0] b,
                                          input logic signed [31:0] a1, input logic signed [31:0] a2,
                                          input logic signed [31:0] a3, input logic signed [31:0] a4,
                                          input logic signed [31:0] a5, input logic signed [31:0] a6);
        longint s;
        longint q;
        s = longint'(b) * 65536 + 13 * (longint'(a1) + longint'(a2))
            - 6 * (longint'(a3) + longint'(a4)) + longint'(a5) + longint'(a6);
`ifdef GS_ROUND_EN
        q = (s >= 0) ? (s + 10) / 20 : (s - 10) / 20;
`else
        q = s / 20;
`endif
        if (q > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (q < -64'sd2147483648) return 32'h8000_0000;
        return q[31:0];
    endfunction

    function automatic logic [31:0] rand_x();
        int v;
        v = $urandom();
        v = v >>> $urandom_range(0, 20);
        return v;
    endfunction

    task automatic drive_x(input logic [15:0] b, input logic [31:0] a1, input logic [31:0] a2,
                           input logic [31:0] a3, input logic [31:0] a4,
                           input logic [31:0] a5, input logic [31:0] a6);
        b_in = b; x1_in = a1; x2_in = a2; x3_in = a3; x4_in = a4; x5_in = a5; x6_in = a6;
    endtask

    // One complete SOLVE phase of NRUN elements; optional reset at element rst_at.
    task automatic run_solve(input int mode, input int rst_at);
        logic [15:0] b;
        logic [31:0] xv [6];
        logic [31:0] e;
        int k;
        for (int i = 0; i < NRUN; i++) begin
            k = i % NE;
            for (int j = 0; j < 6; j++) xv[j] = rand_x();
            b = 16'($urandom_range(0, 65535));
            if (mode == MODE_DIRECT && i < 7) begin
                b = d_b[i];
                xv[0] = d_x1[i]; xv[1] = d_x1[i];
                for (int j = 2; j < 6; j++) xv[j] = 32'h0;
            end else if (mode == MODE_RAMP) begin
                b = 16'(20 * (k + 1));
                for (int j = 0; j < 6; j++) xv[j] = 32'h0;
            end
            if (mode == MODE_DIRECT && i < 7) e = d_e[i];
            else if (mode == MODE_RAMP)       e = 32'(k + 1) << 16;
            else                              e = ref_q(b, xv[0], xv[1], xv[2], xv[3], xv[4], xv[5]);
            drive_x(b, xv[0], xv[1], xv[2], xv[3], xv[4], xv[5]);
            start_in = (i == 0) ? 1'b1 : ((mode == MODE_RAND) ? 1'($urandom_range(0, 1)) : 1'b0);
            if (i == rst_at) rst_in = 1'b1;
            @(posedge clk_in); #1;
            start_in = 1'b0;
            if (i == rst_at) begin
                rst_in = 1'b0;
                n_cmp++;
                if (x_valid_out !== 1'b0 || busy_out !== 1'b0 || result_valid_out !== 1'b0 || x_out !== 32'h0) begin
                    n_bad++;
                    $display("FAIL reset_mid: valid=%b busy=%b rvalid=%b x=%h required 0 0 0 0",
                             x_valid_out, busy_out, result_valid_out, x_out);
                end
                return;
            end
            n_cmp++;
            if (x_valid_out !== 1'b1 || busy_out !== 1'b1) begin
                n_bad++;
                $display("FAIL solve_flags[%0d]: x_valid=%b busy=%b required 1 1", i, x_valid_out, busy_out);
            end
            n_cmp++;
            if (x_out !== e) begin
                n_bad++;
                $display("FAIL x_out[%0d] mode %0d: got %h required %h", i, mode, x_out, e);
            end
            if (i >= NRUN - NE) exp_buf[k] = e;
        end
    endtask

    // Drains NE results; stall_at >= 0 holds ready low for stall_len cycles there,
    // otherwise ready and start_in are randomised.
    task automatic drain(input int stall_at, input int stall_len);
        int idx = 0;
        int stall = 0;
        int cyc = 0;
        logic took;
        while (idx < NE && cyc < 400) begin
            n_cmp++;
            if (result_valid_out !== 1'b1) begin
                n_bad++;
                $display("FAIL drain_valid[%0d]: got %b required 1", idx, result_valid_out);
            end
            n_cmp++;
            if (result_out !== exp_buf[idx]) begin
                n_bad++;
                $display("FAIL drain_data[%0d]: got %h required %h", idx, result_out, exp_buf[idx]);
            end
            if (cyc > 0) begin
                n_cmp++;
                if (x_valid_out !== 1'b0) begin
                    n_bad++;
                    $display("FAIL drain_x_valid: got %b required 0", x_valid_out);
                end
            end
            if (idx == stall_at && stall < stall_len) begin
                result_ready_in = 1'b0;
                stall++;
            end else begin
                result_ready_in = (stall_at < 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            start_in = (stall_at < 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            took = result_ready_in && result_valid_out;
            @(posedge clk_in); #1;
            if (took) idx++;
            cyc++;
        end
        result_ready_in = 1'b0;
        start_in = 1'b0;
        n_cmp++;
        if (idx != NE) begin
            n_bad++;
            $display("FAIL drain_timeout: transferred %0d required %0d", idx, NE);
        end
        n_cmp++;
        if (result_valid_out !== 1'b0 || busy_out !== 1'b0) begin
            n_bad++;
            $display("FAIL drain_end: rvalid=%b busy=%b required 0 0", result_valid_out, busy_out);
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        n_cmp++;
        if (x_out !== 32'h0 || x_valid_out !== 1'b0 || result_valid_out !== 1'b0 ||
            result_out !== 32'h0 || busy_out !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: x=%h xv=%b rv=%b r=%h busy=%b required all 0",
                     x_out, x_valid_out, result_valid_out, result_out, busy_out);
        end
    endtask

    task automatic test_idle();
        for (int i = 0; i < 4; i++) begin
            drive_x(16'($urandom()), rand_x(), rand_x(), rand_x(), rand_x(), rand_x(), rand_x());
            result_ready_in = 1'($urandom_range(0, 1));
            @(posedge clk_in); #1;
            n_cmp++;
            if (x_valid_out !== 1'b0 || busy_out !== 1'b0 || result_valid_out !== 1'b0) begin
                n_bad++;
                $display("FAIL idle_quiet: xv=%b busy=%b rv=%b required 0 0 0",
                         x_valid_out, busy_out, result_valid_out);
            end
        end
        result_ready_in = 1'b0;
    endtask

    task automatic test_arith();
        run_solve(MODE_DIRECT, -1);
        drain(-1, 0);
    endtask

    task automatic test_full_run();
        run_solve(MODE_RAMP, -1);
        drain(3, 5);
    endtask

    task automatic test_reset_mid();
        run_solve(MODE_RAND, NE + 7);
        @(posedge clk_in); #1;
        run_solve(MODE_RAND, -1);
        drain(-1, 0);
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 2; r++) begin
            run_solve(MODE_RAND, -1);
            drain(-1, 0);
        end
    endtask

    initial begin
        rst_in = 1'b1;
        start_in = 1'b0;
        result_ready_in = 1'b0;
        drive_x(16'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        test_reset();
        test_idle();
        test_arith();
        test_full_run();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gs_update_unit.md
Name: gs_update_unit

Overview:
- Arithmetic and control partner of the Gauss-Seidel x/b register file.
- Each cycle it consumes one b value and the six neighbour x values (±1, ±2, ±3) and computes the updated unknown.
- The result is returned on x_out, which feeds the register file's x input.
- It counts elements and iterations, captures the final sweep into an internal result buffer, and streams the 16 solutions out through a valid/ready handshake.

Parameters:
- N_ELEM, 16, number of unknowns per sweep; must be a power of 2.
- N_ITER, 64, number of full sweeps before results are captured; range 1..255.

Ports:
- clk_in  input  1  clock
- rst_in  input  1  synchronous active-high reset
- start_in  input  1  one-cycle pulse; first cycle of element 0, sweep 0
- b_in  input  16  signed integer b for current element
- x1_in  input  32  x[i-1], signed 16.16 fixed point (0 at boundary)
- x2_in  input  32  x[i+1], signed 16.16
- x3_in  input  32  x[i-2], signed 16.16
- x4_in  input  32  x[i+2], signed 16.16
- x5_in  input  32  x[i-3], signed 16.16
- x6_in  input  32  x[i+3], signed 16.16
- x_out  output  32  updated x[i], registered, signed 16.16
- x_valid_out  output  1  x_out holds a new value this cycle
- result_valid_out  output  1  result_out valid
- result_ready_in  input  1  downstream accepts result_out
- result_out  output  32  final x[k], k = 0..N_ELEM-1 in order
- busy_out  output  1  high while SOLVE or DRAIN

Behaviour:
- Reset: synchronous, active-high.
  - All outputs are 0.
  - FSM goes to IDLE; elem_cnt, iter_cnt and rd_ptr are 0.
  - Result buffer contents are don't-care.
- Arithmetic, evaluated every cycle in SOLVE on the current inputs:
  - sum = (b_in<<16) + 13*(x1_in+x2_in) − 6*(x3_in+x4_in) + (x5_in+x6_in).
  - Intermediates are 40-bit signed; no intermediate overflow is allowed.
  - q = sum/20, truncated toward zero.
  - q is saturated to [32'h8000_0000, 32'h7FFF_FFFF].
- Latency: x_out and x_valid_out are registered, one cycle after the inputs are sampled.
  - x_valid_out is high exactly on cycles following a SOLVE cycle.
- FSM:
  - IDLE: wait for start_in=1. Then go to SOLVE; elem_cnt=0, iter_cnt=0. Sample inputs on that same cycle.
  - SOLVE: one element per cycle.
    - elem_cnt increments and wraps N_ELEM−1 → 0.
    - On each wrap, iter_cnt increments.
    - During the sweep with iter_cnt == N_ITER−1, q for element elem_cnt is written to result_buf[elem_cnt].
    - After elem_cnt == N_ELEM−1 of the last sweep, go to DRAIN; rd_ptr=0.
  - DRAIN:
    - result_valid_out=1 and result_out=result_buf[rd_ptr].
    - On result_valid_out && result_ready_in, rd_ptr increments.
    - The transfer with rd_ptr == N_ELEM−1 returns the FSM to IDLE; result_valid_out falls in the next cycle.
    - result_out must be stable while valid is high and ready is low. Ready low for any number of cycles just stalls.
- busy_out = (state != IDLE), registered.
- start_in while in SOLVE or DRAIN is ignored. No restart mid-solve.
- rst_in mid-SOLVE or mid-DRAIN: next cycle is IDLE with all outputs 0; partially drained results are discarded.
- Write-enable on the buffer is gated by the last-sweep condition only. Earlier sweeps never touch it.
- The divide must be exact. Either a sequential-free constant multiply-by-reciprocal with a correction step, or a subtract-based exact method, is acceptable; the result must match truncation toward zero bit-for-bit.

Optional Feature:
- Macro: GS_ROUND_EN.
- Defined: q = sum/20 rounded to nearest, ties away from zero, before saturation.
- Undefined: truncation toward zero as above.
- All other timing and behaviour are identical either way.

Test Plan:
- Exact quotients, no neighbours: x1..x6=0 throughout.
  - b_in=20 → x_out=32'h0001_0000 one cycle later, x_valid_out=1.
  - b_in=−20 → 32'hFFFF_0000.
- Weighted neighbours: b_in=0, x1=x2=32'h0001_0000, others 0 → x_out=32'h0001_4CCC (truncated 1.3).
  - With GS_ROUND_EN: 32'h0001_4CCD.
- Rounding boundary: b_in=1, x=0 → x_out=32'h0000_0CCC.
  - With GS_ROUND_EN: 32'h0000_0CCD.
- Saturation: b_in=32767, x1=x2=32'h7FFF_FFFF, x3..x6=0 → x_out=32'h7FFF_FFFF.
  - Mirror case: b_in=−32768, x1=x2=32'h8000_0000 → 32'h8000_0000.
- Full run: N_ITER=2, start pulse, b_in=20·(k+1) for element k, x=0.
  - busy_out high for 32 SOLVE cycles.
  - Then 16 DRAIN results 32'h0001_0000·(k+1).
  - Hold result_ready_in low 5 cycles at rd_ptr=3 → result_out stays 32'h0004_0000, no skipped or duplicated entries.
  - Then IDLE with busy_out=0.
- Reset mid-operation: assert rst_in at sweep 1, element 7 → next cycle x_valid_out=0, busy_out=0, result_valid_out=0.
  - A fresh start pulse restarts cleanly from element 0, sweep 0.
